// File: rtl/apb4_plic_core_if.sv
// ---------------------------------------------------------------------------
// apb4_plic_core_if
// APB4 bus bundle between a bus master and the PLIC core.
//   paddr   : byte address (only [7:2] decoded by the PLIC)
//   pprot   : protection attributes (ignored by the PLIC)
//   psel    : slave select
//   penable : access phase
//   pwrite  : 1 = write, 0 = read
//   pwdata  : write data
//   pstrb   : byte strobes (ignored, writes are full-word)
//   pready  : slave ready (always 1)
//   prdata  : read data
//   pslverr : slave error (always 0)
// Modports: master drives the request side, slave drives the response side.
// ---------------------------------------------------------------------------
interface apb4_plic_core_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic [3:0]            pstrb;
  logic                  pready;
  logic [31:0]           prdata;
  logic                  pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_plic_core.sv
// ---------------------------------------------------------------------------
// apb4_plic_core
// Platform-level interrupt controller for a single hart, on an APB4 bus.
// Level-triggered sources pass a 2-flop synchronizer into a gateway that
// latches them as pending. Pending, enabled sources whose priority exceeds
// the threshold compete; the highest priority (lowest id on ties) wins.
// Reading CLAIM returns the winner and moves it from pending to in-flight;
// writing its id to CLAIM completes it so the source can pend again.
//
// Ports:
//   clk_i  : the only clock
//   rst_i  : asynchronous, active-high reset
//   apb    : APB4 slave bus (zero wait states, never errors)
//   irq_i  : asynchronous level sources, bit k = id k (id 0 unused)
//   irq_o  : registered interrupt request to the hart
//
// Register map (word offset in paddr[7:2]):
//   0x00 CTRL  [0] global enable
//   0x04 THRES [PRIO_WIDTH-1:0]
//   0x08 CLAIM read = claim, write = complete
//   0x0C PEND  read-only pending bits
//   0x10 EN    enable bits (bit 0 reads 0)
//   0x20-0x2C PRIO, 8 ids per word, 4-bit field per id
// ---------------------------------------------------------------------------
module apb4_plic_core #(
  parameter int NUM_SRC    = 32,
  parameter int PRIO_WIDTH = 3,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  apb4_plic_core_if.slave     apb,
  input  logic [NUM_SRC-1:0]  irq_i,
  output logic                irq_o
);

  localparam logic [5:0] WORD_CTRL  = 6'h00;
  localparam logic [5:0] WORD_THRES = 6'h01;
  localparam logic [5:0] WORD_CLAIM = 6'h02;
  localparam logic [5:0] WORD_PEND  = 6'h03;
  localparam logic [5:0] WORD_EN    = 6'h04;
  localparam logic [5:0] WORD_PRIO0 = 6'h08;
  localparam logic [5:0] WORD_PRIO1 = 6'h09;
  localparam logic [5:0] WORD_PRIO2 = 6'h0A;
  localparam logic [5:0] WORD_PRIO3 = 6'h0B;

  // Id 0 is reserved: this mask keeps it out of pend and en.
  localparam logic [NUM_SRC-1:0] ID0_MASK = NUM_SRC'(1);

  // Bus decode
  logic       access;
  logic       wr_en;
  logic       rd_en;
  logic [5:0] word;

  // State
  logic [NUM_SRC-1:0]    sync1_reg;
  logic [NUM_SRC-1:0]    sync2_reg;
  logic [NUM_SRC-1:0]    pend_reg;
  logic [NUM_SRC-1:0]    pend_next;
  logic [NUM_SRC-1:0]    inflight_reg;
  logic [NUM_SRC-1:0]    inflight_next;
  logic [NUM_SRC-1:0]    en_reg;
  logic                  ctrl_reg;
  logic [PRIO_WIDTH-1:0] thres_reg;
  logic [PRIO_WIDTH-1:0] prio_reg [NUM_SRC];
  logic                  irq_reg;

  // Arbitration
  logic [NUM_SRC-1:0]    elig;
  logic                  any_elig;
  logic [4:0]            winner;
  logic [PRIO_WIDTH-1:0] best_prio;
  logic                  claim;
  logic [NUM_SRC-1:0]    claim_mask;
  logic [NUM_SRC-1:0]    complete_mask;

  // Readback
  logic [127:0] prio_flat;
  logic [31:0]  rd_data;

  // Bus fields the core never looks at.
  logic [ADDR_WIDTH-1:0] paddr_unused;
  logic                  misc_unused;
  assign paddr_unused = apb.paddr;
  assign misc_unused  = ^{apb.pprot, apb.pstrb};

  assign access = apb.psel & apb.penable;
  assign wr_en  = access & apb.pwrite;
  assign rd_en  = access & ~apb.pwrite;
  assign word   = apb.paddr[7:2];

  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;

  // -------------------------------------------------------------------------
  // Eligibility per source and packed priority readback image
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_elig
      assign elig[gi] = pend_reg[gi] & en_reg[gi] & (prio_reg[gi] > thres_reg);
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_prio_flat
      if (gi < NUM_SRC) begin : g_live
        assign prio_flat[4*gi +: 4] = 4'(prio_reg[gi]);
      end else begin : g_none
        assign prio_flat[4*gi +: 4] = 4'h0;
      end
    end
  endgenerate

  assign any_elig = |elig;

  // Winner search: only a strictly higher priority replaces the current
  // choice, so scanning upward leaves ties with the lowest id. An eligible
  // source always has priority > 0, so starting from 0 is safe.
  always_comb begin
    winner    = 5'd0;
    best_prio = '0;
    for (int k = 1; k < NUM_SRC; k++) begin
      if (elig[k] && (prio_reg[k] > best_prio)) begin
        best_prio = prio_reg[k];
        winner    = 5'(k);
      end
    end
  end

  // A claim read with nothing eligible returns 0 and changes nothing.
  assign claim = rd_en && (word == WORD_CLAIM) && (winner != 5'd0);

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int k = 1; k < NUM_SRC; k++) begin
      claim_mask[k]    = claim && (winner == 5'(k));
      // Ids with no matching bit (0 or >= NUM_SRC) complete nothing.
      complete_mask[k] = wr_en && (word == WORD_CLAIM) && (apb.pwdata[4:0] == 5'(k));
    end
  end

  // Gateway: a synced-high source pends unless it is in flight. The claim
  // clear is applied last so it wins over a simultaneous new assertion.
  // Completion clears in-flight here, so re-pending happens a cycle later.
  assign pend_next     = (pend_reg | (sync2_reg & ~inflight_reg)) & ~claim_mask & ~ID0_MASK;
  assign inflight_next = (inflight_reg | claim_mask) & ~complete_mask;

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_reg    <= '0;
      sync2_reg    <= '0;
      pend_reg     <= '0;
      inflight_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      sync1_reg    <= irq_i;
      sync2_reg    <= sync1_reg;
      pend_reg     <= pend_next;
      inflight_reg <= inflight_next;
      irq_reg      <= ctrl_reg & any_elig;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_reg  <= 1'b0;
      thres_reg <= '0;
      en_reg    <= '0;
    end else if (wr_en) begin
      case (word)
        WORD_CTRL:  ctrl_reg  <= apb.pwdata[0];
        WORD_THRES: thres_reg <= apb.pwdata[PRIO_WIDTH-1:0];
        WORD_EN:    en_reg    <= apb.pwdata[NUM_SRC-1:0] & ~ID0_MASK;
        default:    ;
      endcase
    end
  end

  // Priority fields; id 0 is never written and stays 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        prio_reg[k] <= '0;
      end
    end else begin
      for (int k = 1; k < NUM_SRC; k++) begin
        if (wr_en && (word == 6'(8 + k / 8))) begin
          prio_reg[k] <= apb.pwdata[4*(k%8) +: PRIO_WIDTH];
        end
      end
    end
  end

  assign irq_o = irq_reg;

  // -------------------------------------------------------------------------
  // Read mux, combinational in the access phase, 0 otherwise
  // -------------------------------------------------------------------------
  always_comb begin
    rd_data = 32'd0;
    case (word)
      WORD_CTRL:  rd_data = {31'd0, ctrl_reg};
      WORD_THRES: rd_data = 32'(thres_reg);
      WORD_CLAIM: rd_data = 32'(winner);
      WORD_PEND:  rd_data = 32'(pend_reg);
      WORD_EN:    rd_data = 32'(en_reg);
      WORD_PRIO0: rd_data = prio_flat[31:0];
      WORD_PRIO1: rd_data = prio_flat[63:32];
      WORD_PRIO2: rd_data = prio_flat[95:64];
      WORD_PRIO3: rd_data = prio_flat[127:96];
      default:    rd_data = 32'd0;
    endcase
  end

  assign apb.prdata = rd_en ? rd_data : 32'd0;

endmodule

// File: tb/tb_apb4_plic_core.sv
// ---------------------------------------------------------------------------
// tb_apb4_plic_core
// Directed scenarios followed by random traffic, every read and every
// cycle's irq_o compared with a behavioural model of the interrupt
// controller (pending/in-flight sets, priority search by plain arithmetic).
// ---------------------------------------------------------------------------
module tb_apb4_plic_core;
  localparam int NUM_SRC    = 32;
  localparam int PRIO_WIDTH = 3;
  localparam int ADDR_WIDTH = 12;

  localparam logic [11:0] A_CTRL  = 12'h000;
  localparam logic [11:0] A_THRES = 12'h004;
  localparam logic [11:0] A_CLAIM = 12'h008;
  localparam logic [11:0] A_PEND  = 12'h00C;
  localparam logic [11:0] A_EN    = 12'h010;
  localparam logic [11:0] A_PRIO0 = 12'h020;
  localparam logic [11:0] A_PRIO1 = 12'h024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] irq = 32'd0;
  logic        irq_o;

  apb4_plic_core_if #(.ADDR_WIDTH(ADDR_WIDTH)) apb ();

  apb4_plic_core #(
    .NUM_SRC(NUM_SRC), .PRIO_WIDTH(PRIO_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_i(clk), .rst_i(rst), .apb(apb), .irq_i(irq), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  bit m_seen1 [32];   // source level one edge ago
  bit m_seen2 [32];   // source level two edges ago (what the gateway sees)
  bit m_pend  [32];
  bit m_infl  [32];
  bit m_en    [32];
  int m_prio  [32];
  int m_thres;
  bit m_ctrl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) begin
      m_seen1[k] = 0; m_seen2[k] = 0; m_pend[k] = 0;
      m_infl[k] = 0;  m_en[k] = 0;    m_prio[k] = 0;
    end
    m_thres = 0;
    m_ctrl  = 0;
  endtask

  function automatic bit m_elig(input int k);
    return m_pend[k] && m_en[k] && (m_prio[k] > m_thres);
  endfunction

  function automatic int m_winner();
    int best = 0;
    int bp   = 0;
    for (int k = 1; k < NUM_SRC; k++)
      if (m_elig(k) && m_prio[k] > bp) begin
        bp = m_prio[k];
        best = k;
      end
    return best;
  endfunction

  function automatic logic [31:0] m_read(input int w);
    logic [31:0] v = 32'd0;
    case (w)
      0: v[0] = m_ctrl;
      1: v = 32'(m_thres);
      2: v = 32'(m_winner());
      3: for (int k = 0; k < 32; k++) v[k] = m_pend[k];
      4: for (int k = 0; k < 32; k++) v[k] = m_en[k];
      8, 9, 10, 11:
        for (int j = 0; j < 8; j++) v[4*j +: 4] = 4'(m_prio[8*(w-8)+j]);
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // One clock edge: predict the effect of the current inputs, then check irq_o.
  task automatic step();
    bit acc, claim, irq_n;
    int wd, w, cid, id;
    bit pn [32];
    bit fn [32];
    acc   = apb.psel && apb.penable;
    wd    = int'(apb.paddr[7:2]);
    w     = m_winner();
    claim = acc && !apb.pwrite && wd == 2 && w != 0;
    irq_n = 0;
    for (int k = 1; k < NUM_SRC; k++) if (m_elig(k)) irq_n = 1;
    irq_n = irq_n && m_ctrl;
    for (int k = 0; k < 32; k++) begin
      pn[k] = (k != 0) && (m_pend[k] || (m_seen2[k] && !m_infl[k])) && !(claim && k == w);
      fn[k] = m_infl[k] || (claim && k == w);
    end
    if (acc && apb.pwrite) begin
      case (wd)
        0: m_ctrl = apb.pwdata[0];
        1: m_thres = int'(apb.pwdata[2:0]);
        2: begin
          cid = int'(apb.pwdata[4:0]);
          if (cid != 0 && cid < NUM_SRC) fn[cid] = 0;
        end
        4: for (int k = 1; k < 32; k++) m_en[k] = apb.pwdata[k];
        8, 9, 10, 11:
          for (int j = 0; j < 8; j++) begin
            id = 8*(wd-8) + j;
            if (id != 0) m_prio[id] = int'(apb.pwdata[4*j +: 3]);
          end
        default: ;
      endcase
    end
    for (int k = 0; k < 32; k++) begin
      m_pend[k]  = pn[k];
      m_infl[k]  = fn[k];
      m_seen2[k] = m_seen1[k];
      m_seen1[k] = irq[k];
    end
    @(posedge clk);
    #1;
    chk("irq_o", {31'd0, irq_o}, {31'd0, irq_n});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    apb.paddr = addr; apb.pwrite = 1'b1; apb.pwdata = data;
    apb.psel = 1'b1; apb.penable = 1'b0;
    step();
    apb.penable = 1'b1;
    step();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    $display("APB WR addr=0x%03h data=0x%08h", addr, data);
  endtask

  task automatic apb_read(input logic [11:0] addr, input string tag, output logic [31:0] data);
    logic [31:0] exp;
    apb.paddr = addr; apb.pwrite = 1'b0;
    apb.psel = 1'b1; apb.penable = 1'b0;
    step();
    apb.penable = 1'b1;
    #1;
    exp  = m_read(int'(addr[7:2]));
    data = apb.prdata;
    chk(tag, data, exp);
    step();
    apb.psel = 1'b0; apb.penable = 1'b0;
    $display("APB RD addr=0x%03h data=0x%08h", addr, data);
  endtask

  // Reset is asserted wherever the caller stands (possibly mid-transfer).
  task automatic do_reset();
    rst = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    model_reset();
    #1;
    chk("rst_irq_o", {31'd0, irq_o}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] d;
  logic [11:0] addr_list [9] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010,
                                 12'h020, 12'h024, 12'h028, 12'h02C};

  initial begin
    apb.paddr = '0; apb.pprot = 3'd0; apb.psel = 1'b0; apb.penable = 1'b0;
    apb.pwrite = 1'b0; apb.pwdata = 32'd0; apb.pstrb = 4'hF;
    model_reset();
    do_reset();

    // Reset state
    chk("rst_pready", {31'd0, apb.pready}, 32'd1);
    chk("rst_pslverr", {31'd0, apb.pslverr}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      apb_read(addr_list[i], "rst_reg", d);
      chk("rst_reg_zero", d, 32'd0);
    end

    // prdata is 0 outside the access phase
    apb_write(A_CTRL, 32'd1);
    apb.paddr = A_CTRL; apb.pwrite = 1'b0; apb.psel = 1'b1; apb.penable = 1'b0;
    #1;
    chk("prdata_setup", apb.prdata, 32'd0);
    apb.psel = 1'b0;

    // Priority 0 never interrupts
    apb_write(A_EN, 32'h8);
    irq[3] = 1'b1;
    wait_cycles(4);
    apb_read(A_PEND, "gate_pend", d);
    chk("gate_pend_c", d, 32'h8);
    chk("gate_irq", {31'd0, irq_o}, 32'd0);
    apb_write(A_PRIO0, 32'(2) << 12);
    wait_cycles(2);
    chk("gate_irq_prio2", {31'd0, irq_o}, 32'd1);
    irq[3] = 1'b0;
    apb_read(A_CLAIM, "claim3", d);
    chk("claim3_c", d, 32'd3);
    wait_cycles(3);
    apb_write(A_CLAIM, 32'd3);
    wait_cycles(3);

    // Edge-to-irq latency: 4 edges
    irq[3] = 1'b1;
    wait_cycles(3);
    chk("lat_3edges", {31'd0, irq_o}, 32'd0);
    step();
    chk("lat_4edges", {31'd0, irq_o}, 32'd1);
    irq[3] = 1'b0;
    apb_read(A_CLAIM, "claim3b", d);
    wait_cycles(3);
    apb_write(A_CLAIM, 32'd3);

    // Arbitration: equal priority -> lowest id, then higher priority wins
    apb_write(A_EN, (32'd1 << 5) | (32'd1 << 9));
    apb_write(A_PRIO0, 32'(4) << 20);
    apb_write(A_PRIO1, 32'(4) << 4);
    irq[5] = 1'b1; irq[9] = 1'b1;
    wait_cycles(4);
    apb_read(A_CLAIM, "arb_tie", d);
    chk("arb_tie_c", d, 32'd5);
    apb_write(A_PRIO1, 32'(6) << 4);
    apb_read(A_CLAIM, "arb_hi", d);
    chk("arb_hi_c", d, 32'd9);
    apb_read(A_PEND, "arb_pend", d);
    chk("arb_pend9", {31'd0, d[9]}, 32'd0);
    irq[5] = 1'b0; irq[9] = 1'b0;
    wait_cycles(3);
    apb_write(A_CLAIM, 32'd5);
    apb_write(A_CLAIM, 32'd9);

    // Threshold: priority must strictly exceed it
    apb_write(A_PRIO0, 32'(5) << 20);
    apb_write(A_THRES, 32'd5);
    irq[5] = 1'b1;
    wait_cycles(4);
    chk("thr_irq_off", {31'd0, irq_o}, 32'd0);
    apb_read(A_CLAIM, "thr_claim0", d);
    chk("thr_claim0_c", d, 32'd0);
    apb_read(A_PEND, "thr_pend", d);
    chk("thr_pend5", {31'd0, d[5]}, 32'd1);
    apb_write(A_THRES, 32'd4);
    step();
    chk("thr_irq_on", {31'd0, irq_o}, 32'd1);
    irq[5] = 1'b0;
    apb_read(A_CLAIM, "thr_claim5", d);
    chk("thr_claim5_c", d, 32'd5);
    wait_cycles(3);
    apb_write(A_CLAIM, 32'd5);

    // Claim/complete with the source held high
    apb_write(A_THRES, 32'd0);
    apb_write(A_EN, 32'd1 << 7);
    apb_write(A_PRIO0, 32'(3) << 28);
    irq[7] = 1'b1;
    wait_cycles(4);
    apb_read(A_CLAIM, "cc_claim7", d);
    chk("cc_claim7_c", d, 32'd7);
    wait_cycles(2);
    apb_read(A_PEND, "cc_pend_held", d);
    chk("cc_pend7_0", {31'd0, d[7]}, 32'd0);
    apb_write(A_CLAIM, 32'd7);
    apb_read(A_PEND, "cc_pend_back", d);
    chk("cc_pend7_1", {31'd0, d[7]}, 32'd1);

    // Global disable leaves configuration and pending alone
    step();
    chk("gd_irq_before", {31'd0, irq_o}, 32'd1);
    apb_write(A_CTRL, 32'd0);
    step();
    chk("gd_irq_off", {31'd0, irq_o}, 32'd0);
    apb_read(A_EN, "gd_en", d);
    chk("gd_en_c", d, 32'h80);
    apb_read(A_PRIO0, "gd_prio", d);
    chk("gd_prio_c", d, 32'(3) << 28);
    apb_read(A_PEND, "gd_pend", d);
    chk("gd_pend_c", d, 32'h80);
    apb_write(A_CTRL, 32'd1);
    irq[7] = 1'b0;
    apb_read(A_CLAIM, "gd_claim", d);
    wait_cycles(3);
    apb_write(A_CLAIM, 32'd7);

    // Random traffic against the model
    apb_write(A_EN, 32'hFFFF_FFFF);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: irq = $urandom & $urandom;
        1, 2: apb_read(A_CLAIM, "rnd_claim", d);
        3: apb_write(A_CLAIM, 32'($urandom_range(0, 31)));
        4: apb_write(A_EN, $urandom);
        5: apb_write(A_PRIO0 + 12'(4 * $urandom_range(0, 3)), $urandom);
        6: apb_write(A_THRES, $urandom);
        7: apb_write(A_CTRL, 32'($urandom_range(0, 3) != 0));
        8: apb_read(12'($urandom_range(0, 4095)), "rnd_read", d);
        default: step();
      endcase
    end

    // Reset asserted in the access phase of a write aborts it
    irq = 32'd0;
    apb.paddr = A_EN; apb.pwrite = 1'b1; apb.pwdata = 32'hFFFF_FFFF;
    apb.psel = 1'b1; apb.penable = 1'b0;
    step();
    apb.penable = 1'b1;
    #2;
    do_reset();
    apb_read(A_EN, "mid_rst_en", d);
    chk("mid_rst_en_c", d, 32'd0);
    apb_read(A_PEND, "mid_rst_pend", d);
    chk("mid_rst_pend_c", d, 32'd0);
    apb_read(A_CTRL, "mid_rst_ctrl", d);
    chk("mid_rst_ctrl_c", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
